// File: rtl/tower_place_ctrl_if.sv
// Signal bundle between the tower-placer control FSM (master) and the
// key/credit logic plus drawing datapath that surround it (slave).
interface tower_place_ctrl_if;
  logic        key_right;
  logic        key_down;
  logic        key_place;
  logic [9:0]  credits;
  logic        valid;
  logic        square_done;
  logic        erase_square_done;
  logic        tower_done;

  logic        top_left;
  logic        draw_square;
  logic        move_right;
  logic        move_down;
  logic        move_right_wait;
  logic        move_down_wait;
  logic        draw_tower;
  logic        erase_square_right;
  logic        erase_square_down;
  logic        erase_square_tower;
  logic        plot;
  logic        spend;
  logic        tower_placed;
  logic [2:0]  cursor_col;
  logic [2:0]  cursor_row;
  logic [47:0] occupancy;

  modport master (
    input  key_right, key_down, key_place, credits,
           valid, square_done, erase_square_done, tower_done,
    output top_left, draw_square, move_right, move_down,
           move_right_wait, move_down_wait, draw_tower,
           erase_square_right, erase_square_down, erase_square_tower,
           plot, spend, tower_placed, cursor_col, cursor_row, occupancy
  );

  modport slave (
    output key_right, key_down, key_place, credits,
           valid, square_done, erase_square_done, tower_done,
    input  top_left, draw_square, move_right, move_down,
           move_right_wait, move_down_wait, draw_tower,
           erase_square_right, erase_square_down, erase_square_tower,
           plot, spend, tower_placed, cursor_col, cursor_row, occupancy
  );
endinterface

// File: rtl/tower_place_ctrl.sv
// Control FSM for the tower placer: sequences cursor draw/erase/move and tower
// draw on the 8x6 grid, owns the occupancy map and the placement credit check.
module tower_place_ctrl #(
  parameter int TOWER_COST   = 10,
  parameter int TOWER_CYCLES = 1200
) (
  input  logic               clk,
  input  logic               resetn,
  tower_place_ctrl_if.master bus
);

  localparam int               CNT_W    = (TOWER_CYCLES > 1) ? $clog2(TOWER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOWER_CYCLES - 1);
  localparam logic [9:0]       COST     = 10'(TOWER_COST);

  localparam logic [3:0] S_INIT        = 4'd0;
  localparam logic [3:0] S_DRAW_SQ     = 4'd1;
  localparam logic [3:0] S_IDLE        = 4'd2;
  localparam logic [3:0] S_ERASE_R     = 4'd3;
  localparam logic [3:0] S_ERASE_D     = 4'd4;
  localparam logic [3:0] S_MOVE_R      = 4'd5;
  localparam logic [3:0] S_MOVE_D      = 4'd6;
  localparam logic [3:0] S_MOVE_R_WAIT = 4'd7;
  localparam logic [3:0] S_MOVE_D_WAIT = 4'd8;
  localparam logic [3:0] S_ERASE_T     = 4'd9;
  localparam logic [3:0] S_DRAW_T      = 4'd10;

  localparam int B_TOP_LEFT     = 0;
  localparam int B_DRAW_SQUARE  = 1;
  localparam int B_MOVE_RIGHT   = 2;
  localparam int B_MOVE_DOWN    = 3;
  localparam int B_MOVE_R_WAIT  = 4;
  localparam int B_MOVE_D_WAIT  = 5;
  localparam int B_DRAW_TOWER   = 6;
  localparam int B_ERASE_RIGHT  = 7;
  localparam int B_ERASE_DOWN   = 8;
  localparam int B_ERASE_TOWER  = 9;

  localparam int K_DOWN  = 0;
  localparam int K_RIGHT = 1;
  localparam int K_PLACE = 2;

  logic [3:0]       state_q, state_d;
  logic [2:0]       col_q, col_d;
  logic [2:0]       row_q, row_d;
  logic [47:0]      occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       key_q;
  logic             tower_done_q;
  logic [9:0]       strobe_q;
  logic             plot_q;
  logic             placed_q, placed_d;

  logic [2:0]       key_now;
  logic [2:0]       key_rise;
  logic [5:0]       cell_idx;
  logic             cell_busy;
  logic             can_afford;
  logic             tower_rise;

  // One-hot strobe pattern for each state; IDLE drives nothing.
  function automatic logic [9:0] strobe_decode(input logic [3:0] s);
    logic [9:0] v;
    v = '0;
    case (s)
      S_INIT:        v[B_TOP_LEFT]    = 1'b1;
      S_DRAW_SQ:     v[B_DRAW_SQUARE] = 1'b1;
      S_ERASE_R:     v[B_ERASE_RIGHT] = 1'b1;
      S_ERASE_D:     v[B_ERASE_DOWN]  = 1'b1;
      S_MOVE_R:      v[B_MOVE_RIGHT]  = 1'b1;
      S_MOVE_D:      v[B_MOVE_DOWN]   = 1'b1;
      S_MOVE_R_WAIT: v[B_MOVE_R_WAIT] = 1'b1;
      S_MOVE_D_WAIT: v[B_MOVE_D_WAIT] = 1'b1;
      S_ERASE_T:     v[B_ERASE_TOWER] = 1'b1;
      S_DRAW_T:      v[B_DRAW_TOWER]  = 1'b1;
      default:       v = '0;
    endcase
    return v;
  endfunction

  function automatic logic plot_decode(input logic [3:0] s);
    return (s == S_DRAW_SQ) || (s == S_DRAW_T) || (s == S_ERASE_R) ||
           (s == S_ERASE_D) || (s == S_ERASE_T);
  endfunction

  assign key_now    = {bus.key_place, bus.key_right, bus.key_down};
  assign key_rise   = key_now & ~key_q;
  assign cell_idx   = {row_q, col_q};
  assign cell_busy  = occ_q[cell_idx];
  assign can_afford = (bus.credits >= COST);
  // tower_done is sticky in the datapath, so only a fresh rise ends a draw.
  assign tower_rise = bus.tower_done & ~tower_done_q;

  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    placed_d = 1'b0;

    case (state_q)
      S_INIT:    state_d = S_DRAW_SQ;
      S_DRAW_SQ: if (bus.square_done) state_d = S_IDLE;

      S_IDLE: begin
        // A place edge masks coincident move edges even when it is rejected.
        if (key_rise[K_PLACE]) begin
          if (!cell_busy && can_afford) state_d = S_ERASE_T;
        end else if (key_rise[K_RIGHT]) begin
          state_d = cell_busy ? S_MOVE_R : S_ERASE_R;
        end else if (key_rise[K_DOWN]) begin
          state_d = cell_busy ? S_MOVE_D : S_ERASE_D;
        end
      end

      S_ERASE_R: if (bus.erase_square_done) state_d = S_MOVE_R;
      S_ERASE_D: if (bus.erase_square_done) state_d = S_MOVE_D;

      S_MOVE_R: begin
        if (bus.valid) begin
          col_d   = (col_q == 3'd7) ? 3'd0 : col_q + 3'd1;
          state_d = S_MOVE_R_WAIT;
        end
      end

      S_MOVE_D: begin
        if (bus.valid) begin
          row_d   = (row_q == 3'd5) ? 3'd0 : row_q + 3'd1;
          state_d = S_MOVE_D_WAIT;
        end
      end

      // The cursor has already moved, so cell_busy refers to the new cell.
      S_MOVE_R_WAIT, S_MOVE_D_WAIT: state_d = cell_busy ? S_IDLE : S_DRAW_SQ;

      S_ERASE_T: begin
        if (bus.erase_square_done) begin
          cnt_d   = '0;
          state_d = S_DRAW_T;
        end
      end

      S_DRAW_T: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tower_rise || (cnt_q == CNT_LAST)) begin
          occ_d[cell_idx] = 1'b1;
          placed_d        = 1'b1;
          state_d         = S_IDLE;
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_INIT;
      col_q        <= '0;
      row_q        <= '0;
      // NOTE: the occupancy map is plain flops, not a RAM, and must clear on reset.
      occ_q        <= '0;
      cnt_q        <= '0;
      key_q        <= '0;
      tower_done_q <= 1'b0;
      strobe_q     <= '0;
      plot_q       <= 1'b0;
      placed_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      occ_q        <= occ_d;
      cnt_q        <= cnt_d;
      key_q        <= key_now;
      tower_done_q <= bus.tower_done;
      strobe_q     <= strobe_decode(state_q);
      plot_q       <= plot_decode(state_q);
      placed_q     <= placed_d;
    end
  end

  assign bus.top_left           = strobe_q[B_TOP_LEFT];
  assign bus.draw_square        = strobe_q[B_DRAW_SQUARE];
  assign bus.move_right         = strobe_q[B_MOVE_RIGHT];
  assign bus.move_down          = strobe_q[B_MOVE_DOWN];
  assign bus.move_right_wait    = strobe_q[B_MOVE_R_WAIT];
  assign bus.move_down_wait     = strobe_q[B_MOVE_D_WAIT];
  assign bus.draw_tower         = strobe_q[B_DRAW_TOWER];
  assign bus.erase_square_right = strobe_q[B_ERASE_RIGHT];
  assign bus.erase_square_down  = strobe_q[B_ERASE_DOWN];
  assign bus.erase_square_tower = strobe_q[B_ERASE_TOWER];
  assign bus.plot               = plot_q;
  assign bus.spend              = placed_q;
  assign bus.tower_placed       = placed_q;
  assign bus.cursor_col         = col_q;
  assign bus.cursor_row         = row_q;
  assign bus.occupancy          = occ_q;

endmodule

// File: tb/tb_tower_place_ctrl.sv
// Randomized bench for tower_place_ctrl: a responsive datapath model drives the
// completion flags and a grid-level model predicts strobe order, cursor and map.
`timescale 1ns/1ps
module tb_tower_place_ctrl;

  localparam int TOWER_COST   = 10;
  localparam int TOWER_CYCLES = 1200;

  localparam int K_RIGHT = 0;
  localparam int K_DOWN  = 1;
  localparam int K_PLACE = 2;
  localparam int K_BOTH  = 3;

  // Strobe ids: 0 top_left, 1 draw_square, 2 move_right, 3 move_down,
  // 4 move_right_wait, 5 move_down_wait, 6 draw_tower, 7..9 erase right/down/tower.
  localparam logic [9:0] PLOT_MASK = 10'b1111000010;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  tower_place_ctrl_if bus ();

  tower_place_ctrl #(
    .TOWER_COST  (TOWER_COST),
    .TOWER_CYCLES(TOWER_CYCLES)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- datapath responder ----------------
  int tower_rise_at = -1;
  bit tower_stuck   = 1'b0;

  initial begin : datapath
    int sq_wait, er_wait, mv_wait, tw_cnt;
    bus.valid = 1'b0; bus.square_done = 1'b0;
    bus.erase_square_done = 1'b0; bus.tower_done = 1'b0;
    sq_wait = 0; er_wait = 0; mv_wait = 0; tw_cnt = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        bus.valid = 1'b0; bus.square_done = 1'b0;
        bus.erase_square_done = 1'b0; bus.tower_done = 1'b0;
        continue;
      end
      if (bus.draw_square) begin
        if (sq_wait == 0) bus.square_done = 1'b1; else sq_wait--;
      end else begin
        bus.square_done = 1'b0; sq_wait = $urandom_range(0, 4);
      end
      if (bus.erase_square_right || bus.erase_square_down || bus.erase_square_tower) begin
        if (er_wait == 0) bus.erase_square_done = 1'b1; else er_wait--;
      end else begin
        bus.erase_square_done = 1'b0; er_wait = $urandom_range(0, 4);
      end
      if (bus.move_right || bus.move_down) begin
        if (mv_wait == 0) bus.valid = 1'b1; else mv_wait--;
      end else begin
        if (bus.move_right_wait || bus.move_down_wait) bus.valid = 1'b0;
        mv_wait = $urandom_range(0, 4);
      end
      if (bus.erase_square_tower) begin
        bus.tower_done = tower_stuck;
        tw_cnt = 0;
      end else if (bus.draw_tower) begin
        tw_cnt++;
        if (tw_cnt == tower_rise_at) bus.tower_done = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- observation ----------------
  int seen_id[$];
  int seen_len[$];
  logic [9:0] prev_s;
  int onehot_viol, plot_viol, spend_cnt, tp_cnt;

  function automatic logic [9:0] strobes();
    return {bus.erase_square_tower, bus.erase_square_down, bus.erase_square_right,
            bus.draw_tower, bus.move_down_wait, bus.move_right_wait,
            bus.move_down, bus.move_right, bus.draw_square, bus.top_left};
  endfunction

  function automatic int low_id(input logic [9:0] s);
    for (int i = 0; i < 10; i++) if (s[i]) return i;
    return -1;
  endfunction

  task automatic clear_mon();
    seen_id.delete(); seen_len.delete();
    prev_s = '0; onehot_viol = 0; plot_viol = 0; spend_cnt = 0; tp_cnt = 0;
  endtask

  task automatic step();
    logic [9:0] s;
    @(negedge clk);
    s = strobes();
    if ($countones(s) > 1) onehot_viol++;
    if (bus.plot !== (|(s & PLOT_MASK))) plot_viol++;
    if (bus.spend) spend_cnt++;
    if (bus.tower_placed) tp_cnt++;
    if (s != '0 && s != prev_s) begin
      seen_id.push_back(low_id(s));
      seen_len.push_back(1);
    end else if (s != '0) begin
      seen_len[seen_len.size()-1] = seen_len[seen_len.size()-1] + 1;
    end
    prev_s = s;
  endtask

  // ---------------- grid-level reference model ----------------
  logic [47:0] occ_m;
  int col_m, row_m;
  int exp_id[$];
  int exp_len[$];
  int exp_spend;
  int op_no = 0;

  task automatic expect_strobe(input int id, input int len);
    exp_id.push_back(id);
    exp_len.push_back(len);
  endtask

  task automatic compare_op(input string name);
    check({name, "/seq_len"}, 64'(seen_id.size()), 64'(exp_id.size()));
    for (int i = 0; i < exp_id.size() && i < seen_id.size(); i++) begin
      check($sformatf("%s/strobe%0d", name, i), 64'(seen_id[i]), 64'(exp_id[i]));
      if (exp_len[i] >= 0)
        check($sformatf("%s/len%0d", name, i), 64'(seen_len[i]), 64'(exp_len[i]));
    end
    check({name, "/spend"},     64'(spend_cnt),      64'(exp_spend));
    check({name, "/placed"},    64'(tp_cnt),         64'(exp_spend));
    check({name, "/col"},       64'(bus.cursor_col), 64'(col_m));
    check({name, "/row"},       64'(bus.cursor_row), 64'(row_m));
    check({name, "/occupancy"}, 64'(bus.occupancy),  64'(occ_m));
    check({name, "/onehot"},    64'(onehot_viol),    64'(0));
    check({name, "/plot"},      64'(plot_viol),      64'(0));
  endtask

  // Steps until the controller has been quiet for 4 cycles (bounded).
  task automatic wait_quiet(input string name, input int noise_key);
    int quiet, cycles;
    bit started;
    quiet = 0; cycles = 0; started = 1'b0;
    while (quiet < 4 && cycles < 3000) begin
      step();
      cycles++;
      if (strobes() != '0 || bus.spend || bus.tower_placed) begin
        quiet = 0;
        // A key edge raised while busy must be ignored.
        if (!started) begin
          if (noise_key == K_RIGHT) bus.key_right = 1'b1;
          if (noise_key == K_DOWN)  bus.key_down  = 1'b1;
          if (noise_key == K_PLACE) bus.key_place = 1'b1;
        end
        started = 1'b1;
      end else begin
        quiet++;
      end
    end
    check({name, "/completed"}, 64'(quiet >= 4), 64'(1));
  endtask

  task automatic run_op(input int kind, input int cr, input int rise,
                        input bit stuck, input bit noise);
    int idx, dt_len, noise_key;
    bit free_cell;
    string name;
    name = $sformatf("op%0d", op_no);
    op_no++;
    clear_mon();
    exp_id.delete(); exp_len.delete(); exp_spend = 0;
    idx = row_m * 8 + col_m;
    free_cell = !occ_m[idx];
    noise_key = -1;
    case (kind)
      K_RIGHT: begin
        if (free_cell) expect_strobe(7, -1);
        expect_strobe(2, -1);
        expect_strobe(4, 1);
        col_m = (col_m + 1) % 8;
        if (!occ_m[row_m * 8 + col_m]) expect_strobe(1, -1);
        if (noise) noise_key = K_DOWN;
      end
      K_DOWN: begin
        if (free_cell) expect_strobe(8, -1);
        expect_strobe(3, -1);
        expect_strobe(5, 1);
        row_m = (row_m + 1) % 6;
        if (!occ_m[row_m * 8 + col_m]) expect_strobe(1, -1);
        if (noise) noise_key = K_PLACE;
      end
      default: begin
        if (free_cell && cr >= TOWER_COST) begin
          expect_strobe(9, -1);
          // A flag raised after n strobe cycles is seen one edge later.
          if (stuck || rise < 1) dt_len = TOWER_CYCLES;
          else dt_len = (rise + 1 < TOWER_CYCLES) ? rise + 1 : TOWER_CYCLES;
          expect_strobe(6, dt_len);
          occ_m[idx] = 1'b1;
          exp_spend = 1;
        end
        if (noise && kind == K_PLACE) noise_key = K_RIGHT;
      end
    endcase
    bus.credits   = cr[9:0];
    tower_rise_at = rise;
    tower_stuck   = stuck;
    bus.key_right = (kind == K_RIGHT) || (kind == K_BOTH);
    bus.key_down  = (kind == K_DOWN);
    bus.key_place = (kind == K_PLACE) || (kind == K_BOTH);
    wait_quiet(name, noise_key);
    bus.key_right = 1'b0; bus.key_down = 1'b0; bus.key_place = 1'b0;
    step();
    step();
    compare_op(name);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "/strobes"},   64'(strobes()),      64'(0));
    check({name, "/plot"},      64'(bus.plot),       64'(0));
    check({name, "/spend"},     64'(bus.spend),      64'(0));
    check({name, "/placed"},    64'(bus.tower_placed), 64'(0));
    check({name, "/col"},       64'(bus.cursor_col), 64'(0));
    check({name, "/row"},       64'(bus.cursor_row), 64'(0));
    check({name, "/occupancy"}, 64'(bus.occupancy),  64'(0));
  endtask

  // Releases reset and expects top_left for one cycle then a cursor draw.
  task automatic run_init(input string name);
    clear_mon();
    exp_id.delete(); exp_len.delete(); exp_spend = 0;
    occ_m = '0; col_m = 0; row_m = 0;
    expect_strobe(0, 1);
    expect_strobe(1, -1);
    @(negedge clk);
    resetn = 1'b1;
    wait_quiet(name, -1);
    compare_op(name);
  endtask

  task automatic reset_during_tower();
    int cycles, cnt;
    for (int i = 0; i < 48 && occ_m[row_m * 8 + col_m]; i++) run_op(K_RIGHT, 0, 1, 1'b0, 1'b0);
    tower_rise_at = -1;
    tower_stuck   = 1'b0;
    bus.credits   = 10'd20;
    bus.key_place = 1'b1;
    cycles = 0; cnt = 0;
    while (cnt < 20 && cycles < 300) begin
      step();
      cycles++;
      if (bus.draw_tower) cnt++;
    end
    check("rst_mid/draw_reached", 64'(cnt), 64'(20));
    #1 resetn = 1'b0;
    #1 check_reset_outputs("rst_mid");
    bus.key_place = 1'b0;
    step();
    step();
    run_init("rst_mid_init");
  endtask

  initial begin
    resetn = 1'b0;
    bus.key_right = 1'b0; bus.key_down = 1'b0; bus.key_place = 1'b0;
    bus.credits = '0;
    occ_m = '0; col_m = 0; row_m = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    run_init("init");

    // Walk to (7,2), then wrap right to (0,2).
    run_op(K_DOWN, 0, 1, 1'b0, 1'b0);
    run_op(K_DOWN, 0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) run_op(K_RIGHT, 0, 1, 1'b0, 1'b1);
    run_op(K_RIGHT, 0, 1, 1'b0, 1'b0);
    // Tower at (3,5) so the later move from (3,4) lands on an occupied cell.
    for (int i = 0; i < 3; i++) run_op(K_RIGHT, 0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_op(K_DOWN, 0, 1, 1'b0, 1'b0);
    run_op(K_PLACE, 12, 20, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) run_op(K_DOWN, 0, 1, 1'b0, 1'b0);
    run_op(K_PLACE, 10, 50, 1'b0, 1'b1);    // (3,4): bit 35
    run_op(K_PLACE, 10, 50, 1'b0, 1'b0);    // occupied: rejected
    run_op(K_DOWN, 0, 1, 1'b0, 1'b0);       // onto occupied (3,5)
    run_op(K_DOWN, 0, 1, 1'b0, 1'b0);       // wraps to (3,0)
    run_op(K_PLACE, 9, 10, 1'b0, 1'b0);     // too few credits
    run_op(K_PLACE, 15, 5, 1'b1, 1'b0);     // tower_done stuck: full timeout
    run_op(K_RIGHT, 0, 1, 1'b0, 1'b0);
    run_op(K_BOTH, 10, 5, 1'b0, 1'b0);      // place beats right

    for (int i = 0; i < 60; i++) begin
      int r, k, cr, rise;
      r    = int'($urandom_range(0, 99));
      k    = (r < 35) ? K_RIGHT : (r < 65) ? K_DOWN : (r < 93) ? K_PLACE : K_BOTH;
      cr   = int'($urandom_range(0, 20));
      rise = (i == 30) ? -1 : int'($urandom_range(1, 60));
      run_op(k, cr, rise, 1'b0, ($urandom_range(0, 1) == 1) && (k != K_BOTH));
    end

    reset_during_tower();

    for (int i = 0; i < 10; i++) begin
      int k;
      k = int'($urandom_range(0, 2));
      run_op(k, int'($urandom_range(5, 20)), int'($urandom_range(1, 30)), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
